// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: drives the memory's write/read enables and addresses and tracks occupancy and status.
// Optional sticky overflow/underflow outputs are enabled by defining SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic                  rd_req,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned       DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                full_q, empty_q, afull_q, aempty_q;
  logic                push, pop;

  // Acceptance uses the registered flags, so a push and pop in the same
  // cycle can never touch the same address.
  assign push = wr_req & ~full_q;
  assign pop  = rd_req & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + ONE;
    if (pop)  rptr_d = rptr_q + ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AF_C);
      aempty_q <= (count_d <= AE_C);
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (wr_req & full_q);
      underflow_q <= underflow_q | (rd_req & empty_q);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign mem_wr_en    = push;
  assign mem_rd_en    = pop;
  assign mem_waddr    = wptr_q[ADDR_WIDTH-1:0];
  assign mem_raddr    = rptr_q[ADDR_WIDTH-1:0];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl (DEPTH 4): reference model of pointers/flags plus a memory
// model whose read data is scoreboarded against the order of accepted writes.
module tb_sync_fifo_ctrl;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  sync_fifo_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
    .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Memory with one-cycle registered read and a valid strobe
  logic [7:0] mem [4];
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [7:0] exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (mem_wr_en) mem[mem_waddr] <= wdata;
      rvalid <= mem_rd_en;
      if (mem_rd_en) rdata <= mem[mem_raddr];
    end
  end

  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rdata_unexpected: got %0h, required no valid (queue empty)", rdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          fails++;
          $display("FAIL rdata: got %0h, required %0h", rdata, e);
        end
      end
    end
  end

  // Reference model
  logic [2:0] m_wp = '0, m_rp = '0;
  int         m_cnt = 0;
  logic       m_ovf = 1'b0, m_unf = 1'b0;

  task automatic model_reset();
    m_wp = '0; m_rp = '0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag);
    tests++;
    if (count !== m_cnt[AW:0] || full !== (m_cnt == 4) || empty !== (m_cnt == 0) ||
        almost_full !== (m_cnt >= 3) || almost_empty !== (m_cnt <= 1)) begin
      fails++;
      $display("FAIL %s_flags: got cnt=%0d f=%b e=%b af=%b ae=%b, required cnt=%0d f=%b e=%b af=%b ae=%b",
               tag, count, full, empty, almost_full, almost_empty,
               m_cnt, m_cnt == 4, m_cnt == 0, m_cnt >= 3, m_cnt <= 1);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    tests++;
    if (overflow !== m_ovf || underflow !== m_unf) begin
      fails++;
      $display("FAIL %s_err: got ovf=%b unf=%b, required ovf=%b unf=%b",
               tag, overflow, underflow, m_ovf, m_unf);
    end
`endif
  endtask

  // One clock cycle of stimulus with combinational checks before the edge
  // and registered checks after it.
  task automatic step(input logic w, input logic r);
    logic push_ok, pop_ok;
    @(negedge clk);
    wr_req = w; rd_req = r; wdata = 8'($urandom);
    push_ok = w && (m_cnt != 4);
    pop_ok  = r && (m_cnt != 0);
    #1;
    tests++;
    if (mem_wr_en !== push_ok || mem_rd_en !== pop_ok) begin
      fails++;
      $display("FAIL enables: got wr=%b rd=%b, required wr=%b rd=%b", mem_wr_en, mem_rd_en, push_ok, pop_ok);
    end
    if (push_ok) begin
      tests++;
      if (mem_waddr !== m_wp[AW-1:0]) begin
        fails++;
        $display("FAIL waddr: got %0d, required %0d", mem_waddr, m_wp[AW-1:0]);
      end
      exp_q.push_back(wdata);
    end
    if (pop_ok) begin
      tests++;
      if (mem_raddr !== m_rp[AW-1:0]) begin
        fails++;
        $display("FAIL raddr: got %0d, required %0d", mem_raddr, m_rp[AW-1:0]);
      end
    end
    if (w && m_cnt == 4) m_ovf = 1'b1;
    if (r && m_cnt == 0) m_unf = 1'b1;
    if (push_ok) m_wp = m_wp + 3'd1;
    if (pop_ok)  m_rp = m_rp + 3'd1;
    m_cnt = m_cnt + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
    @(posedge clk);
    #1;
    wr_req = 1'b0; rd_req = 1'b0;
    check_flags("step");
    tests++;
    if (rvalid !== pop_ok) begin
      fails++;
      $display("FAIL rvalid_latency: got %b, required %b", rvalid, pop_ok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset");
    tests++;
    if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || mem_waddr !== '0 || mem_raddr !== '0) begin
      fails++;
      $display("FAIL reset_mem: got wr=%b rd=%b wa=%0d ra=%0d, required 0 0 0 0",
               mem_wr_en, mem_rd_en, mem_waddr, mem_raddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic test_empty_both();
    step(1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] d;
    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      d = mem_waddr - mem_raddr;
      tests++;
      if (d !== 2'd2) begin
        fails++;
        $display("FAIL addr_lag: got waddr=%0d raddr=%0d, required lag 2", mem_waddr, mem_raddr);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got cnt=%0d e=%b f=%b, required 0 1 0", count, empty, full);
    end
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_empty_both();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
